// File: rtl/face_rec_seq.sv
// face_rec_seq: sequences clear, load, projection and match phases of one recognition pass.
module face_rec_seq #(
  parameter int NUM_PIXELS  = 161,
  parameter int COLS_SIZE   = 8,
  parameter int NUM_SAMPLES = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        done_flg,
  output logic        enable_mean,
  output logic        enable_face,
  output logic        enable_p,
  output logic        enable_r,
  output logic        enable_out_logic,
  output logic        clear_m,
  output logic        clear_f,
  output logic        clear_p,
  output logic        clear_r,
  output logic        clear_out_logic,
  output logic [15:0] pixel_iter,
  output logic [3:0]  eigen_iter,
  output logic [8:0]  weight_iter,
  output logic [8:0]  sample_iter,
  output logic        busy,
  output logic [2:0]  phase,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_M, LOAD_F, LOAD_P, PROJ, MATCH, WAIT_D} state_t;
  localparam logic [15:0] P_LAST = 16'(NUM_PIXELS - 1);
  localparam logic [3:0]  E_LAST = 4'(COLS_SIZE - 1);
  localparam logic [8:0]  W_LAST = 9'(COLS_SIZE - 1);
  localparam logic [8:0]  S_LAST = 9'(NUM_SAMPLES - 1);
  state_t      state, nxt;
  logic [15:0] pix_n;
  logic [3:0]  eig_n;
  logic [8:0]  wt_n, smp_n;
  logic        done_n, ab, acc, pix_last;
  // abort only counts outside IDLE, so start+abort in IDLE still starts a pass
  assign ab       = abort && state != IDLE;
  assign in_ready = state inside {LOAD_M, LOAD_F, LOAD_P} && !ab;
  assign acc      = in_valid && in_ready;
  assign pix_last = pixel_iter == P_LAST;
  assign enable_mean      = state == LOAD_M && acc;
  assign enable_face      = state == LOAD_F && acc;
  assign enable_p         = state == LOAD_P && acc;
  assign enable_r         = state == PROJ && !ab;
  assign enable_out_logic = state == MATCH && !ab;
  assign clear_m          = state == CLEAR;
  assign clear_f          = clear_m;
  assign clear_p          = clear_m;
  assign clear_r          = clear_m;
  assign clear_out_logic  = clear_m;
  assign busy             = state != IDLE;
  assign phase            = state;
  always_comb begin
    nxt    = state;
    pix_n  = pixel_iter;
    eig_n  = eigen_iter;
    wt_n   = weight_iter;
    smp_n  = sample_iter;
    done_n = 1'b0;
    if (ab || state == CLEAR) begin
      nxt   = ab ? IDLE : LOAD_M;
      pix_n = '0;
      eig_n = '0;
      wt_n  = '0;
      smp_n = '0;
    end else begin
      case (state)
        IDLE: nxt = start ? CLEAR : IDLE;
        LOAD_M, LOAD_F: if (acc) begin
          pix_n = pix_last ? '0 : pixel_iter + 16'd1;
          if (pix_last) nxt = state == LOAD_M ? LOAD_F : LOAD_P;
        end
        LOAD_P: if (acc) begin
          pix_n = pix_last ? '0 : pixel_iter + 16'd1;
          if (pix_last) eig_n = eigen_iter == E_LAST ? '0 : eigen_iter + 4'd1;
          if (pix_last && eigen_iter == E_LAST) nxt = PROJ;
        end
        PROJ: begin
          pix_n = pix_last ? '0 : pixel_iter + 16'd1;
          if (pix_last) wt_n = weight_iter == W_LAST ? '0 : weight_iter + 9'd1;
          if (pix_last && weight_iter == W_LAST) nxt = MATCH;
        end
        MATCH: begin
          smp_n = sample_iter == S_LAST ? '0 : sample_iter + 9'd1;
          if (sample_iter == S_LAST) nxt = WAIT_D;
        end
        WAIT_D: if (done_flg) begin
          done_n = 1'b1;
          nxt    = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      pixel_iter  <= '0;
      eigen_iter  <= '0;
      weight_iter <= '0;
      sample_iter <= '0;
      done        <= 1'b0;
    end else begin
      state       <= nxt;
      pixel_iter  <= pix_n;
      eigen_iter  <= eig_n;
      weight_iter <= wt_n;
      sample_iter <= smp_n;
      done        <= done_n;
    end
endmodule
